// File: rtl/video_frame_capture.sv
// video_frame_capture
//   1bpp loopback capture of the core video stream. Each active pixel is
//   registered once (S1), thresholded on the green channel and written into
//   a framebuffer through a small FIFO with a valid/ready write port.
//   Reports frame completion, a per-frame error flag and a sticky overflow.
//
//   Optional build macro: VIDEO_CAPTURE_STATS_EN
//     defined   -> pixels_per_line / lines_per_frame are live and the
//                  run-length / line-count checks feed frame_error.
//     undefined -> both measurement outputs are 0 and frame_error only
//                  reflects out-of-range addresses.

module video_frame_capture #(
  parameter int         H_ACTIVE   = 320,
  parameter int         V_ACTIVE   = 288,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] THRESH     = 8'h40
) (
  input  logic        clk_core_12288,
  input  logic        reset,
  input  logic        capture_enable,
  input  logic [23:0] video_rgb,
  input  logic        video_de,
  input  logic        video_vs,
  input  logic        video_hs,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [16:0] wr_addr,
  output logic        wr_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overflow,
  output logic [9:0]  pixels_per_line,
  output logic [9:0]  lines_per_frame
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [17:0] PIX_TOTAL = 18'(H_ACTIVE * V_ACTIVE);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic de;
    logic vs;
    logic lit;
  } s1_t;

  typedef struct packed {
    logic [16:0] addr;
    logic        pix;
  } ent_t;

  s1_t         s1;
  logic [1:0]  state, state_nxt;
  logic [17:0] addr_cnt;
  logic        frm_err;
  logic        geo_err_set;

  ent_t        mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic capt_start, in_range, push_req, oor, empty, full;
  logic pop, push, drop, drain_done;

  // red/blue and hs are carried by the stream but not needed here
  logic unused_inputs;
  assign unused_inputs = ^{video_hs, video_rgb[23:16], video_rgb[7:0]};

  // S1: register the video stream; threshold folded into the same stage
  always_ff @(posedge clk_core_12288) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.de  <= video_de;
      s1.vs  <= video_vs;
      s1.lit <= (video_rgb[15:8] >= THRESH);
    end
  end

  assign capt_start = (state == ST_ARMED) && capture_enable && s1.vs;
  assign in_range   = (addr_cnt < PIX_TOTAL);
  assign push_req   = (state == ST_CAPT) && s1.de && in_range;
  assign oor        = (state == ST_CAPT) && s1.de && !in_range;
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign pop        = !empty && wr_ready;
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  // no pushes happen in DRAIN, so the FIFO is empty after this edge
  assign drain_done = (state == ST_DRAIN) && (empty || ((count == ONE_CNT) && pop));

  // next-state: capture runs between two vs pulses, then drains the FIFO
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (capture_enable) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!capture_enable)  state_nxt = ST_IDLE;
        else if (s1.vs)       state_nxt = ST_CAPT;
      end
      ST_CAPT:  if (s1.vs) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = capture_enable ? ST_ARMED : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_core_12288) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // pixel address counter; saturates so a runaway frame cannot wrap back in range
  always_ff @(posedge clk_core_12288) begin
    if (reset) begin
      addr_cnt <= '0;
    end else if (capt_start) begin
      addr_cnt <= '0;
    end else if ((state == ST_CAPT) && s1.de && (addr_cnt != 18'h3FFFF)) begin
      addr_cnt <= addr_cnt + 18'd1;
    end
  end

  // per-frame error flag, cleared when a new frame starts
  always_ff @(posedge clk_core_12288) begin
    if (reset)                    frm_err <= 1'b0;
    else if (capt_start)          frm_err <= 1'b0;
    else if (oor || geo_err_set)  frm_err <= 1'b1;
  end

  // FIFO storage; data needs no reset since outputs are masked when empty
  always_ff @(posedge clk_core_12288) begin
    if (push) mem[wr_ptr] <= '{addr: addr_cnt[16:0], pix: s1.lit};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_core_12288) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  assign wr_valid = !empty;
  assign wr_addr  = empty ? '0   : mem[rd_ptr].addr;
  assign wr_data  = empty ? 1'b0 : mem[rd_ptr].pix;

  // frame completion status and sticky overflow
  always_ff @(posedge clk_core_12288) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_done <= drain_done;
      if (drain_done) frame_error <= frm_err;
      if (drop)       overflow    <= 1'b1;
    end
  end

`ifdef VIDEO_CAPTURE_STATS_EN
  localparam logic [9:0] H_CNT = 10'(H_ACTIVE);
  localparam logic [9:0] V_CNT = 10'(V_ACTIVE);

  logic       de_q;
  logic       de_fall;
  logic [9:0] x_cnt, line_cnt, lines_now, ppl_q, lpf_q;

  assign de_fall   = de_q && !s1.de;
  // a run ending on the closing vs cycle still counts as a line
  assign lines_now = line_cnt + {9'd0, de_fall};

  // geometry checks: run length at each de fall, line count at closing vs
  always_comb begin
    geo_err_set = 1'b0;
    if (state == ST_CAPT) begin
      if (de_fall && (x_cnt != H_CNT))    geo_err_set = 1'b1;
      if (s1.vs && (lines_now != V_CNT))  geo_err_set = 1'b1;
    end
  end

  // previous S1 de for fall detection
  always_ff @(posedge clk_core_12288) begin
    if (reset) de_q <= 1'b0;
    else       de_q <= s1.de;
  end

  // run-length / line counters and the published measurements
  always_ff @(posedge clk_core_12288) begin
    if (reset) begin
      x_cnt    <= '0;
      line_cnt <= '0;
      ppl_q    <= '0;
      lpf_q    <= '0;
    end else if (capt_start) begin
      x_cnt    <= '0;
      line_cnt <= '0;
    end else if (state == ST_CAPT) begin
      if (s1.de) begin
        if (x_cnt != 10'h3FF) x_cnt <= x_cnt + 10'd1;
      end else if (de_fall) begin
        x_cnt <= '0;
        ppl_q <= x_cnt;
        if (line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
      end
      if (s1.vs) lpf_q <= lines_now;
    end
  end

  assign pixels_per_line = ppl_q;
  assign lines_per_frame = lpf_q;
`else
  assign geo_err_set     = 1'b0;
  assign pixels_per_line = '0;
  assign lines_per_frame = '0;
`endif

endmodule

// File: tb/tb_video_frame_capture.sv
// Bench for video_frame_capture: small frame geometry, randomized pixels
// and backpressure, scoreboard of expected framebuffer writes.
module tb_video_frame_capture;

  localparam int         H  = 20;
  localparam int         V  = 6;
  localparam int         D  = 8;
  localparam logic [7:0] TH = 8'h40;
`ifdef VIDEO_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_core_12288 = 1'b0;
  logic        reset = 1'b1;
  logic        capture_enable = 1'b0;
  logic [23:0] video_rgb = '0;
  logic        video_de = 1'b0, video_vs = 1'b0, video_hs = 1'b0;
  logic        wr_ready = 1'b1;
  logic        wr_valid, wr_data, frame_done, frame_error, overflow;
  logic [16:0] wr_addr;
  logic [9:0]  pixels_per_line, lines_per_frame;

  video_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .THRESH(TH)) dut (
    .clk_core_12288(clk_core_12288), .reset(reset), .capture_enable(capture_enable),
    .video_rgb(video_rgb), .video_de(video_de), .video_vs(video_vs), .video_hs(video_hs),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_error(frame_error), .overflow(overflow),
    .pixels_per_line(pixels_per_line), .lines_per_frame(lines_per_frame)
  );

  always #5 clk_core_12288 = ~clk_core_12288;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [17:0] exp_q[$];
  int  pix_idx, last_len, rdy_mode, fd_cnt = 0;
  bit  rng_err, geo_err, ovf_exp = 1'b0, lat_chk = 1'b0;

  // monitor: scoreboard writes, count frame_done, head stability under stall
  logic [17:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  always @(negedge clk_core_12288) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && wr_valid) check("head_stable", wr_addr, prev_addr);
      if (wr_valid && wr_ready) begin
        check("wr_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", wr_addr, mon_e[17:1]);
          check("wr_data", wr_data, mon_e[0]);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
    end
  end

  task automatic cyc();
    @(posedge clk_core_12288);
    #1;
  endtask

  task automatic drive_line(input int len, input int y, input int gmode);
    logic [7:0] g;
    int lows;
    lows = 3;
    video_hs = 1'b1; cyc(); video_hs = 1'b0; cyc(); cyc();
    for (int x = 0; x < len; x++) begin
      if (lat_chk && y == 0 && x == 1) check("latency_n1", wr_valid, 1'b0);
      if (lat_chk && y == 0 && x == 2) check("latency_n2", wr_valid, 1'b1);
      case (gmode)
        0:       g = 8'hFF;
        1:       g = (x == 5 && y == 2) ? 8'h40 : 8'h3F;
        default: g = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'h40 : 8'h3F)
                                                 : 8'($urandom_range(0, 255));
      endcase
      video_rgb = {8'($urandom), g, 8'($urandom)};
      video_de  = 1'b1;
      if (rdy_mode == 2 && y == 0) wr_ready = 1'b0;
      else if (rdy_mode == 1 && lows > 0 && $urandom_range(0, 3) == 0) begin
        wr_ready = 1'b0;
        lows--;
      end else wr_ready = 1'b1;
      // framebuffer rule: linear address, in range only, stalled-line tail dropped
      if (pix_idx < H * V) begin
        if (!(rdy_mode == 2 && y == 0 && x >= D)) exp_q.push_back({17'(pix_idx), g >= TH});
      end else rng_err = 1'b1;
      pix_idx++;
      cyc();
    end
    video_de = 1'b0; video_rgb = '0;
    if (len != H) geo_err = 1'b1;
    last_len = len;
    repeat (3) cyc();
    wr_ready = 1'b1;
    repeat (12) cyc();
  endtask

  task automatic run_frame(input int nlines, input int short_y, input int gmode,
                           input int rmode, input int drop_y);
    int fd0;
    bit exp_err;
    fd0 = fd_cnt;
    pix_idx = 0; rng_err = 1'b0; geo_err = 1'b0; rdy_mode = rmode;
    video_vs = 1'b1; cyc(); video_vs = 1'b0;
    repeat (4) cyc();
    for (int y = 0; y < nlines; y++) begin
      if (y == drop_y) capture_enable = 1'b0;
      drive_line((y == short_y) ? H - 1 : H, y, gmode);
    end
    repeat (4) cyc();
    video_vs = 1'b1; cyc(); video_vs = 1'b0;
    for (int t = 0; t < 400 && fd_cnt == fd0; t++) cyc();
    check("frame_done", fd_cnt, fd0 + 1);
    exp_err = rng_err || (STATS && (geo_err || nlines != V));
    check("frame_error", frame_error, exp_err);
    check("writes_left", exp_q.size(), 0);
    check("overflow", overflow, ovf_exp);
    check("pixels_per_line", pixels_per_line, STATS ? last_len : 0);
    check("lines_per_frame", lines_per_frame, STATS ? nlines : 0);
    repeat (6) cyc();
    check("done_once", fd_cnt, fd0 + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd1;
    repeat (3) cyc();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 17'd0);
    check("rst_wr_data", wr_data, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_ppl", pixels_per_line, 10'd0);
    check("rst_lpf", lines_per_frame, 10'd0);
    reset = 1'b0; capture_enable = 1'b1;
    repeat (3) cyc();

    lat_chk = 1'b1;
    run_frame(V, -1, 0, 0, -1);          // nominal, all lit
    lat_chk = 1'b0;
    run_frame(V, -1, 1, 0, -1);          // single lit pixel at x=5,y=2
    for (int i = 0; i < 3; i++) run_frame(V, -1, 2, 1, -1);  // random pixels / ready
    run_frame(V, 3, 2, 1, -1);           // one short line
    run_frame(V + 1, -1, 2, 0, -1);      // one extra line
    ovf_exp = 1'b1;
    run_frame(V, -1, 2, 2, -1);          // stall whole first line -> drops

    // reset mid-capture with a non-empty FIFO
    video_vs = 1'b1; cyc(); video_vs = 1'b0;
    repeat (3) cyc();
    wr_ready = 1'b0; video_de = 1'b1; video_rgb = 24'h00FF00;
    repeat (6) cyc();
    video_de = 1'b0; video_rgb = '0; cyc();
    check("pre_reset_valid", wr_valid, 1'b1);
    reset = 1'b1; cyc();
    check("mid_rst_wr_valid", wr_valid, 1'b0);
    check("mid_rst_wr_addr", wr_addr, 17'd0);
    check("mid_rst_frame_error", frame_error, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_ppl", pixels_per_line, 10'd0);
    check("mid_rst_lpf", lines_per_frame, 10'd0);
    reset = 1'b0; ovf_exp = 1'b0; exp_q.delete(); wr_ready = 1'b1;
    fd1 = fd_cnt;
    repeat (40) cyc();
    check("no_done_after_reset", fd_cnt, fd1);
    check("valid_after_reset", wr_valid, 1'b0);

    // enable dropped mid-frame: frame completes, then nothing is captured
    run_frame(V, -1, 2, 0, 2);
    fd1 = fd_cnt;
    video_vs = 1'b1; cyc(); video_vs = 1'b0;
    repeat (3) cyc();
    video_de = 1'b1; video_rgb = 24'h00FF00;
    repeat (H) cyc();
    video_de = 1'b0; video_rgb = '0;
    repeat (20) cyc();
    check("idle_no_done", fd_cnt, fd1);
    check("idle_wr_valid", wr_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
